axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
- Shares the single downstream AXI4 master port between two upstream requesters.
  - m0: IFU, read-only.
  - m1: LSU, read and write.
- Reads are arbitrated, with at most one read transaction outstanding downstream.
- LSU writes pass straight through and are not arbitrated.
- Sits between the core's IFU/LSU and the io_master interface of the top-level CPU.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- ID_W, 4, transaction ID width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- m0_arvalid/m0_arready  in/out  1/1  IFU AR handshake.
- m0_araddr,m0_arid,m0_arlen,m0_arsize,m0_arburst  in  ADDR_W/ID_W/8/3/2  IFU AR payload.
- m0_rvalid/m0_rready  out/in  1/1  IFU R handshake.
- m0_rdata,m0_rresp,m0_rlast,m0_rid  out  DATA_W/2/1/ID_W  IFU R payload.
- m1_ar*, m1_r*  same set as m0  LSU read channels.
- m1_aw*, m1_w*, m1_b*  full AXI4 AW/W/B bundles  LSU write channels, wired to s_aw*/s_w*/s_b* with no logic.
- s_arvalid/s_arready  out/in  1/1  downstream AR handshake.
- s_araddr,s_arid,s_arlen,s_arsize,s_arburst  out  ADDR_W/ID_W/8/3/2  downstream AR payload.
- s_rvalid/s_rready  in/out  1/1  downstream R handshake.
- s_rdata,s_rresp,s_rlast,s_rid  in  DATA_W/2/1/ID_W  downstream R payload.
- burst_err  out  1  sticky flag: s_rlast disagreed with the beat count.

Behaviour:
- States: IDLE, AR0, R0, AR1, R1. Reset state is IDLE.
- Reset values: all *ready and *valid outputs are 0, burst_err is 0, last_grant is m0.
- IDLE:
  - Sample m0_arvalid and m1_arvalid.
  - Only one valid: go to ARx for that master.
  - Both valid: the winner comes from the policy (see Optional Feature).
  - Neither valid: stay in IDLE.
  - Record the winner in last_grant.
- ARx:
  - s_ar* = mx_ar* (combinational mux).
  - s_arvalid = mx_arvalid.
  - mx_arready = s_arready; the other master's arready = 0.
  - On s_arvalid & s_arready: latch arlen into beat_cnt and go to Rx.
  - Latency: request seen in IDLE at cycle N, s_arvalid asserted at N+1.
- Rx:
  - mx_r* = s_r*.
  - mx_rvalid = s_rvalid; s_rready = mx_rready.
  - The other master's rvalid = 0.
  - Every handshake decrements beat_cnt.
  - On a handshake with s_rlast: go to IDLE.
  - Beat-count checks:
    - s_rlast while beat_cnt != 0: set burst_err.
    - beat_cnt == 0 without s_rlast: set burst_err and still go to IDLE.
- Outside ARx and Rx: all arready and rready outputs are 0; s_arvalid = 0.
- A master that drops arvalid while in ARx (AXI violation) sends the FSM back to IDLE without issuing.
- Burst length ranges up to 256 beats (arlen 0..255); beat_cnt is 8 bits, and the decrement after reaching 0 is not performed.
- The write path is independent. Ordering between LSU reads and LSU writes is the LSU's responsibility.
- burst_err is cleared only by reset.
- Asserting reset mid-burst forces IDLE asynchronously and drops all valids and readies immediately.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a tie in IDLE, grant the master that is not last_grant.
- Undefined: fixed priority, m1 (LSU) always wins ties; last_grant is still updated but not used.

Test Plan:
- Single m0 read: araddr=0x80000000, arlen=0; slave returns rdata=0x00000413 with rlast -> m0 receives 1 beat, m1_rvalid stays 0, FSM returns to IDLE, burst_err=0.
- Both request in the same cycle (m0 addr 0x80000100, m1 addr 0x80000200), round-robin build, last_grant=m0 -> m1 is issued first, m0 is issued in the cycle after m1's rlast+1; the fixed-priority build also issues m1 first.
- m1 burst with arlen=3 (4 beats, INCR) while m0 requests mid-burst -> m0_arready stays 0 until the 4th beat with rlast, then m0 is granted.
- s_rlast asserted on beat 2 of an arlen=3 burst -> burst_err=1, FSM goes to IDLE; burst_err stays 1 after later clean transactions.
- Reset pulled low while in R0 with s_rvalid=1 -> m0_rvalid and s_rready are 0 in the same cycle; after release the FSM is in IDLE and a new m0 read completes normally.
- m1 write to 0xa00003f8 with wdata=0x41, wstrb=0x1, overlapping an m0 read -> the AW/W/B handshakes pass through unchanged and the read completes unaffected.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//   Shares one downstream AXI4 master port between the IFU (m0, read-only)
//   and the LSU (m1, read + write). Reads are arbitrated with at most one
//   read transaction outstanding downstream; LSU writes are wired straight
//   through to the downstream AW/W/B channels.
//
// Ports
//   clock, reset        : system clock, asynchronous active-low reset
//   m0_ar*/m0_r*        : IFU read address / read data channels
//   m1_ar*/m1_r*        : LSU read address / read data channels
//   m1_aw*/m1_w*/m1_b*  : LSU write channels (pass-through)
//   s_ar*/s_r*          : downstream read channels
//   s_aw*/s_w*/s_b*     : downstream write channels (pass-through)
//   burst_err           : sticky, s_rlast disagreed with the expected beat count
//
// Build option
//   ARB_ROUND_ROBIN_EN  : defined -> on a tie the master that did not win the
//                         previous grant wins; undefined -> LSU wins every tie.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  // IFU read
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic [ID_W-1:0]   m0_rid,
  // LSU read
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic [ID_W-1:0]   m1_rid,
  // LSU write
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic [ID_W-1:0]   m1_awid,
  input  logic [7:0]        m1_awlen,
  input  logic [2:0]        m1_awsize,
  input  logic [1:0]        m1_awburst,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic              m1_wlast,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  output logic [1:0]        m1_bresp,
  output logic [ID_W-1:0]   m1_bid,
  // downstream read
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [ID_W-1:0]   s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic [ID_W-1:0]   s_rid,
  // downstream write
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [ID_W-1:0]   s_awid,
  output logic [7:0]        s_awlen,
  output logic [2:0]        s_awsize,
  output logic [1:0]        s_awburst,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic              s_wlast,
  input  logic              s_bvalid,
  output logic              s_bready,
  input  logic [1:0]        s_bresp,
  input  logic [ID_W-1:0]   s_bid,
  // status
  output logic              burst_err
);

  typedef enum logic [2:0] {IDLE, AR0, R0, AR1, R1} state_t;

  state_t     state_reg;
  logic [7:0] beat_cnt_reg;
  logic       last_grant_reg;   // 0 = m0, 1 = m1
  logic       burst_err_reg;

  logic sel_m1;
  logic cur_arvalid;
  logic r_hs;
  logic tie_pick_m1;
  logic grant_m1;

  // Payload muxes are steered by the owning master; only the valids and
  // readies are gated by state, so reset drops them immediately.
  assign sel_m1      = (state_reg == AR1) || (state_reg == R1);
  assign cur_arvalid = sel_m1 ? m1_arvalid : m0_arvalid;

  assign s_araddr  = sel_m1 ? m1_araddr  : m0_araddr;
  assign s_arid    = sel_m1 ? m1_arid    : m0_arid;
  assign s_arlen   = sel_m1 ? m1_arlen   : m0_arlen;
  assign s_arsize  = sel_m1 ? m1_arsize  : m0_arsize;
  assign s_arburst = sel_m1 ? m1_arburst : m0_arburst;

  assign s_arvalid  = ((state_reg == AR0) && m0_arvalid) || ((state_reg == AR1) && m1_arvalid);
  assign m0_arready = (state_reg == AR0) && s_arready;
  assign m1_arready = (state_reg == AR1) && s_arready;

  assign m0_rvalid = (state_reg == R0) && s_rvalid;
  assign m1_rvalid = (state_reg == R1) && s_rvalid;
  assign s_rready  = ((state_reg == R0) && m0_rready) || ((state_reg == R1) && m1_rready);
  assign r_hs      = s_rvalid && s_rready;

  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m0_rlast = s_rlast;
  assign m0_rid   = s_rid;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_rlast = s_rlast;
  assign m1_rid   = s_rid;

  // Write path: plain wires, no arbitration.
  assign s_awvalid  = m1_awvalid;
  assign m1_awready = s_awready;
  assign s_awaddr   = m1_awaddr;
  assign s_awid     = m1_awid;
  assign s_awlen    = m1_awlen;
  assign s_awsize   = m1_awsize;
  assign s_awburst  = m1_awburst;
  assign s_wvalid   = m1_wvalid;
  assign m1_wready  = s_wready;
  assign s_wdata    = m1_wdata;
  assign s_wstrb    = m1_wstrb;
  assign s_wlast    = m1_wlast;
  assign m1_bvalid  = s_bvalid;
  assign s_bready   = m1_bready;
  assign m1_bresp   = s_bresp;
  assign m1_bid     = s_bid;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_pick_m1 = ~last_grant_reg;
`else
  // Fixed priority: LSU always wins. last_grant is still tracked so both
  // builds carry the same state; OR-ing it in keeps it referenced.
  assign tie_pick_m1 = 1'b1 | last_grant_reg;
`endif

  assign grant_m1  = m1_arvalid && (!m0_arvalid || tie_pick_m1);
  assign burst_err = burst_err_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      beat_cnt_reg   <= 8'd0;
      last_grant_reg <= 1'b0;
      burst_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m0_arvalid || m1_arvalid) begin
            last_grant_reg <= grant_m1;
            state_reg      <= grant_m1 ? AR1 : AR0;
          end
        end
        AR0, AR1: begin
          // A master withdrawing arvalid abandons the request; nothing issued.
          if (!cur_arvalid) begin
            state_reg <= IDLE;
          end else if (s_arready) begin
            beat_cnt_reg <= s_arlen;
            state_reg    <= sel_m1 ? R1 : R0;
          end
        end
        R0, R1: begin
          if (r_hs) begin
            if (s_rlast) begin
              if (beat_cnt_reg != 8'd0) burst_err_reg <= 1'b1;
              state_reg <= IDLE;
            end else if (beat_cnt_reg == 8'd0) begin
              // Expected last beat arrived without rlast: flag and give up.
              burst_err_reg <= 1'b1;
              state_reg     <= IDLE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg - 8'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
